// File: rtl/elevator_pkg.sv
// Shared types and motor codes for the elevator car controller and its call scanner.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DN   = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DN   = 2'b10;

endpackage

// File: rtl/elevator_call_scan.sv
// Combinational scan of the latched calls relative to one evaluation floor:
// calls above/below/at the floor and whether a car arriving there must stop.
module elevator_call_scan #(
  parameter int NUM_FLOORS = 11,
  parameter int FW         = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pend_up_i,
  input  logic [NUM_FLOORS-1:0] pend_dn_i,
  input  logic [NUM_FLOORS-1:0] pend_car_i,
  input  logic [FW-1:0]         floor_i,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  here_o,
  output logic                  stop_up_o,
  output logic                  stop_dn_o
);

  localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

  logic [NUM_FLOORS-1:0] any_w;
  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;
  logic [NUM_FLOORS-1:0] at_mask;

  assign any_w = pend_up_i | pend_dn_i | pend_car_i;

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_mask
    localparam logic [FW-1:0] FI = FW'(gi);
    assign above_mask[gi] = (FI > floor_i);
    assign below_mask[gi] = (FI < floor_i);
    assign at_mask[gi]    = (FI == floor_i);
  end

  assign above_o = |(any_w & above_mask);
  assign below_o = |(any_w & below_mask);
  assign here_o  = |(any_w & at_mask);

  // An opposite-direction hall call only stops the car when nothing lies further on.
  assign stop_up_o = (|((pend_car_i | pend_up_i) & at_mask))
                   | ((|(pend_dn_i & at_mask)) & ~above_o)
                   | (floor_i == TOP_FLOOR);
  assign stop_dn_o = (|((pend_car_i | pend_dn_i) & at_mask))
                   | ((|(pend_up_i & at_mask)) & ~below_o)
                   | (floor_i == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Single-car SCAN controller with latched hall/car calls, travel and door timers.
// Optional emergency stop input enabled by defining ELEV_CAR_ESTOP_EN.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 11,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8,
  parameter int FW            = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ELEV_CAR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_dn_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  output logic [1:0]            motor_signal,
  output logic [FW-1:0]         cur_floor,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_dn,
  output logic [NUM_FLOORS-1:0] pend_car
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [FW-1:0]         TOP_FLOOR   = FW'(NUM_FLOORS - 1);
  localparam logic [TW-1:0]         TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]         DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0    = NUM_FLOORS'(1);
  localparam logic [NUM_FLOORS-1:0] UP_VALID    = ~(ONE_HOT0 << (NUM_FLOORS - 1));
  localparam logic [NUM_FLOORS-1:0] DN_VALID    = ~ONE_HOT0;

  state_t                state_q;
  dir_t                  dir_q;
  logic [FW-1:0]         cur_floor_q;
  logic [1:0]            motor_q;
  logic                  door_q;
  logic [TW-1:0]         travel_cnt_q;
  logic [DW-1:0]         door_cnt_q;
  logic [NUM_FLOORS-1:0] pend_up_q, pend_dn_q, pend_car_q;
  logic [NUM_FLOORS-1:0] pend_up_d, pend_dn_d, pend_car_d;

  logic                  run;
  logic [NUM_FLOORS-1:0] up_req, dn_req;
  logic [FW-1:0]         eval_floor;
  logic [NUM_FLOORS-1:0] eval_oh;
  logic                  above, below, here, stop_up, stop_dn;
  logic                  travel_tc, door_tc, door_entry, door_hold, beyond, restart;
  logic [NUM_FLOORS-1:0] car_mask, up_mask, dn_mask;
  logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_dn;

`ifdef ELEV_CAR_ESTOP_EN
  assign run          = ~estop;
  // The motor drops immediately on estop rather than a cycle later.
  assign motor_signal = run ? motor_q : MOTOR_STOP;
`else
  assign run          = 1'b1;
  assign motor_signal = motor_q;
`endif

  assign cur_floor = cur_floor_q;
  assign door_open = door_q;
  assign pend_up   = pend_up_q;
  assign pend_dn   = pend_dn_q;
  assign pend_car  = pend_car_q;

  assign up_req = hall_up_req & UP_VALID;
  assign dn_req = hall_dn_req & DN_VALID;

  // While moving, the scanner looks at the floor about to be reached.
  always_comb begin
    eval_floor = cur_floor_q;
    if (state_q == MOVE_UP && cur_floor_q != TOP_FLOOR) begin
      eval_floor = cur_floor_q + FW'(1);
    end else if (state_q == MOVE_DN && cur_floor_q != '0) begin
      eval_floor = cur_floor_q - FW'(1);
    end
  end

  assign eval_oh = ONE_HOT0 << eval_floor;

  elevator_call_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FW         (FW)
  ) u_scan (
    .pend_up_i  (pend_up_q),
    .pend_dn_i  (pend_dn_q),
    .pend_car_i (pend_car_q),
    .floor_i    (eval_floor),
    .above_o    (above),
    .below_o    (below),
    .here_o     (here),
    .stop_up_o  (stop_up),
    .stop_dn_o  (stop_dn)
  );

  assign travel_tc  = (travel_cnt_q == TRAVEL_LAST);
  assign door_tc    = (door_cnt_q == DOOR_LAST);
  assign door_hold  = run && (state_q == DOOR_OPEN);
  assign beyond     = (dir_q == DIR_UP) ? above : below;
  assign door_entry = run && ((state_q == IDLE && here)
                           || (state_q == MOVE_UP && travel_tc && stop_up)
                           || (state_q == MOVE_DN && travel_tc && stop_dn));

  always_comb begin
    car_mask   = door_hold ? eval_oh : '0;
    up_mask    = (door_hold && dir_q == DIR_UP) ? eval_oh : '0;
    dn_mask    = (door_hold && dir_q == DIR_DN) ? eval_oh : '0;
    restart    = |((car_req & car_mask) | (up_req & up_mask) | (dn_req & dn_mask));
    clr_car    = door_entry ? eval_oh : '0;
    clr_up     = (door_entry && (dir_q == DIR_UP || !beyond)) ? eval_oh : '0;
    clr_dn     = (door_entry && (dir_q == DIR_DN || !beyond)) ? eval_oh : '0;
    pend_car_d = (pend_car_q | (car_req & ~car_mask)) & ~clr_car;
    pend_up_d  = (pend_up_q  | (up_req  & ~up_mask))  & ~clr_up;
    pend_dn_d  = (pend_dn_q  | (dn_req  & ~dn_mask))  & ~clr_dn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      dir_q        <= DIR_UP;
      cur_floor_q  <= '0;
      motor_q      <= MOTOR_STOP;
      door_q       <= 1'b0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
      pend_up_q    <= '0;
      pend_dn_q    <= '0;
      pend_car_q   <= '0;
    end else begin
      pend_up_q  <= pend_up_d;
      pend_dn_q  <= pend_dn_d;
      pend_car_q <= pend_car_d;
      if (run) begin
        case (state_q)
          IDLE: begin
            if (here) begin
              state_q    <= DOOR_OPEN;
              door_q     <= 1'b1;
              door_cnt_q <= '0;
              motor_q    <= MOTOR_STOP;
            end else if (above && (dir_q == DIR_UP || !below)) begin
              state_q      <= MOVE_UP;
              dir_q        <= DIR_UP;
              motor_q      <= MOTOR_UP;
              travel_cnt_q <= '0;
            end else if (below) begin
              state_q      <= MOVE_DN;
              dir_q        <= DIR_DN;
              motor_q      <= MOTOR_DN;
              travel_cnt_q <= '0;
            end
          end
          MOVE_UP, MOVE_DN: begin
            if (travel_tc) begin
              travel_cnt_q <= '0;
              cur_floor_q  <= eval_floor;
              if ((state_q == MOVE_UP) ? stop_up : stop_dn) begin
                state_q    <= DOOR_OPEN;
                motor_q    <= MOTOR_STOP;
                door_q     <= 1'b1;
                door_cnt_q <= '0;
              end
            end else begin
              travel_cnt_q <= travel_cnt_q + TW'(1);
            end
          end
          DOOR_OPEN: begin
            if (restart) begin
              door_cnt_q <= '0;
            end else if (door_tc) begin
              state_q    <= IDLE;
              door_q     <= 1'b0;
              door_cnt_q <= '0;
            end else begin
              door_cnt_q <= door_cnt_q + DW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Scoreboarded bench: expected door-opening floors are queued as calls are
// placed and popped by a monitor each time the door opens.
module tb_elevator_car_ctrl;

  localparam int NF = 11;

  logic          clk;
  logic          rst;
  logic [NF-1:0] hall_up_req, hall_dn_req, car_req;
  logic [1:0]    motor_signal;
  logic [3:0]    cur_floor;
  logic          door_open;
  logic [NF-1:0] pend_up, pend_dn, pend_car;
`ifdef ELEV_CAR_ESTOP_EN
  logic          estop;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  int exp_floor;
  logic door_prev = 1'b0;

  elevator_car_ctrl dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ELEV_CAR_ESTOP_EN
    .estop        (estop),
`endif
    .hall_up_req  (hall_up_req),
    .hall_dn_req  (hall_dn_req),
    .car_req      (car_req),
    .motor_signal (motor_signal),
    .cur_floor    (cur_floor),
    .door_open    (door_open),
    .pend_up      (pend_up),
    .pend_dn      (pend_dn),
    .pend_car     (pend_car)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_door(input logic lvl, input string tag);
    int n = 0;
    while (door_open !== lvl && n < 300) begin
      tick(1);
      n++;
    end
    if (door_open !== lvl) check_eq(tag, int'(door_open), int'(lvl));
  endtask

  task automatic wait_floor(input int f, input string tag);
    int n = 0;
    while (int'(cur_floor) != f && n < 300) begin
      tick(1);
      n++;
    end
    if (int'(cur_floor) != f) check_eq(tag, int'(cur_floor), f);
  endtask

  task automatic count_motor(input logic [1:0] code, output int n);
    n = 0;
    while (motor_signal == code && n < 200) begin
      n++;
      tick(1);
    end
  endtask

  // Door monitor: every rising door_open is one transaction.
  always @(posedge clk) begin
    #2;
    if (door_open === 1'b1 && door_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        check_eq("door_unexpected", exp_q.size(), 1);
      end else begin
        exp_floor = exp_q.pop_front();
        $display("door open at floor %0d (expected %0d) cycle %0d", cur_floor, exp_floor, cyc);
        check_eq("door_floor", int'(cur_floor), exp_floor);
        check_eq("door_clr_car", int'(pend_car[cur_floor]), 0);
      end
    end
    door_prev = door_open;
  end

  initial begin
    int n;
    int t0;
    rst = 1'b1;
    hall_up_req = '0;
    hall_dn_req = '0;
    car_req = '0;
`ifdef ELEV_CAR_ESTOP_EN
    estop = 1'b0;
`endif
    #2 rst = 1'b0;
    #1;
    check_eq("rst_motor", int'(motor_signal), 0);
    check_eq("rst_floor", int'(cur_floor), 0);
    check_eq("rst_door", int'(door_open), 0);
    check_eq("rst_pend", int'(pend_up | pend_dn | pend_car), 0);
    tick(2);
    rst = 1'b1;

    // Hall down call at 7 from floor 0.
    hall_dn_req[7] = 1'b1;
    exp_q.push_back(7);
    tick(1);
    hall_dn_req = '0;
    check_eq("t1_pend_dn", int'(pend_dn), 1 << 7);
    check_eq("t1_motor_wait", int'(motor_signal), 0);
    tick(1);
    n = 0;
    while (motor_signal == 2'b01 && n < 200) begin
      check_eq("t1_floor_step", int'(cur_floor), n / 4);
      n++;
      tick(1);
    end
    check_eq("t1_motor_cycles", n, 28);
    check_eq("t1_door_open", int'(door_open), 1);
    check_eq("t1_pend_dn_clr", int'(pend_dn), 0);
    t0 = cyc;

    // Car calls 9 and 2 while the door is open at 7, heading up.
    tick(2);
    car_req[9] = 1'b1;
    car_req[2] = 1'b1;
    exp_q.push_back(9);
    exp_q.push_back(2);
    tick(1);
    car_req = '0;
    check_eq("t2_pend_car", int'(pend_car), (1 << 9) | (1 << 2));
    wait_door(1'b0, "t1_door_close_timeout");
    check_eq("t1_door_cycles", cyc - t0, 8);
    check_eq("t1_idle_motor", int'(motor_signal), 0);
    wait_door(1'b1, "t2_door9_timeout");
    wait_door(1'b0, "t2_close9_timeout");
    tick(1);
    count_motor(2'b10, n);
    check_eq("t2_down_cycles", n, 28);
    check_eq("t2_floor2", int'(cur_floor), 2);

    // Up call at 7; down call at 6 latched while passing 5.
    wait_door(1'b0, "t2_close2_timeout");
    hall_up_req[7] = 1'b1;
    exp_q.push_back(7);
    tick(1);
    hall_up_req = '0;
    wait_floor(5, "t3_floor5_timeout");
    check_eq("t3_motor_up", int'(motor_signal), 1);
    hall_dn_req[6] = 1'b1;
    exp_q.push_back(6);
    tick(1);
    hall_dn_req = '0;
    wait_door(1'b1, "t3_door7_timeout");
    check_eq("t3_dn6_kept", int'(pend_dn), 1 << 6);
    check_eq("t3_up7_clr", int'(pend_up), 0);
    wait_door(1'b0, "t3_close7_timeout");
    wait_door(1'b1, "t3_door6_timeout");
    check_eq("t3_dn6_clr", int'(pend_dn), 0);
    wait_door(1'b0, "t3_close6_timeout");

    // Door restart at floor 3 when door_cnt is 6.
    car_req[3] = 1'b1;
    exp_q.push_back(3);
    tick(1);
    car_req = '0;
    wait_door(1'b1, "t4_door3_timeout");
    t0 = cyc;
    tick(6);
    car_req[3] = 1'b1;
    tick(1);
    car_req = '0;
    check_eq("t4_car3_not_latched", int'(pend_car), 0);
    wait_door(1'b0, "t4_close3_timeout");
    check_eq("t4_door_cycles", cyc - t0, 15);
    check_eq("t4_car3_after", int'(pend_car), 0);

    // Asynchronous reset while moving past floor 4.
    car_req[8] = 1'b1;
    tick(1);
    car_req = '0;
    wait_floor(4, "t5_floor4_timeout");
    check_eq("t5_pend_car8", int'(pend_car), 1 << 8);
    #2 rst = 1'b0;
    #1;
    check_eq("t5_rst_motor", int'(motor_signal), 0);
    check_eq("t5_rst_floor", int'(cur_floor), 0);
    check_eq("t5_rst_door", int'(door_open), 0);
    check_eq("t5_rst_pend", int'(pend_up | pend_dn | pend_car), 0);
    tick(1);
    rst = 1'b1;
    tick(2);
    check_eq("t5_idle_motor", int'(motor_signal), 0);

`ifdef ELEV_CAR_ESTOP_EN
    // Estop for 10 cycles at travel_cnt 2 on the way to floor 1.
    car_req[1] = 1'b1;
    exp_q.push_back(1);
    tick(1);
    car_req = '0;
    n = 0;
    while (motor_signal != 2'b01 && n < 50) begin
      tick(1);
      n++;
    end
    check_eq("es_motor_start", int'(motor_signal), 1);
    t0 = cyc;
    tick(2);
    estop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("es_motor_stop", int'(motor_signal), 0);
      tick(1);
    end
    estop = 1'b0;
    #1;
    check_eq("es_motor_resume", int'(motor_signal), 1);
    wait_floor(1, "es_floor1_timeout");
    check_eq("es_floor_delay", cyc - t0, 14);
    wait_door(1'b1, "es_door1_timeout");
`endif

    tick(3);
    check_eq("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
- Parametrised single-car controller; next generation of the fixed 11-floor lift logic inside elevator_system.
- Generalised to NUM_FLOORS floors, with configurable per-floor travel time and door dwell time.
- Adds latched hall/car call registers, SCAN (collective) direction preference and a door timer.
- A system top instantiates one per car. Hall calls arrive already routed to this car by an external dispatcher.

Parameters:
- NUM_FLOORS, 11, number of floors; floor 0 is the bottom.
- TRAVEL_CYCLES, 4, clock cycles to move one floor; must be >= 1.
- DOOR_CYCLES, 8, clock cycles the door stays open; must be >= 1.
- FW, $clog2(NUM_FLOORS), floor index width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hall_up_req  in  NUM_FLOORS  hall up-call pulses or levels, one bit per floor.
- hall_dn_req  in  NUM_FLOORS  hall down-call pulses or levels, one bit per floor.
- car_req  in  NUM_FLOORS  in-car floor buttons.
- motor_signal  out  2  00 stop, 01 up, 10 down; 11 never driven.
- cur_floor  out  FW  current floor index.
- door_open  out  1  door open indicator.
- pend_up  out  NUM_FLOORS  latched up-calls.
- pend_dn  out  NUM_FLOORS  latched down-calls.
- pend_car  out  NUM_FLOORS  latched car calls.

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE, cur_floor=0, dir=UP;
  - motor_signal=00, door_open=0;
  - all pend_* =0;
  - travel_cnt=0, door_cnt=0.
- Call latching: each cycle pend_x <= (pend_x | x_req) & ~clr_x. Set wins over clear only when the floor differs from cur_floor.
- Request bits are ignored where meaningless: hall_up_req[NUM_FLOORS-1] and hall_dn_req[0].
- Derived signals: above = any pending at a floor > cur_floor; below = any pending at a floor < cur_floor; here = pend_car|pend_up|pend_dn at cur_floor.
- States: IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN.
- IDLE, evaluated in priority order:
  - here -> DOOR_OPEN.
  - else above and (dir==UP or !below) -> MOVE_UP, dir=UP.
  - else below -> MOVE_DN, dir=DN.
  - else stay in IDLE. dir holds.
- MOVE_UP:
  - motor_signal=01; travel_cnt counts 0..TRAVEL_CYCLES-1.
  - On terminal count: cur_floor+1, travel_cnt=0.
  - Stop at the new floor f if pend_car[f] | pend_up[f] | (pend_dn[f] & no pending above f), or if f is the top floor. A stop goes to DOOR_OPEN; otherwise keep moving.
- MOVE_DN: mirror of MOVE_UP, motor_signal=10. Floor 0 forces a stop.
- cur_floor never wraps. The moves above and below are only entered when there is a call beyond the current floor.
- DOOR_OPEN:
  - motor_signal=00, door_open=1; door_cnt counts 0..DOOR_CYCLES-1, then -> IDLE with door_open=0.
  - Clearing on entry:
    - pend_car[f] is always cleared.
    - pend_up[f] is cleared if dir==UP, or if no pending call lies beyond f in dir.
    - pend_dn[f] is cleared symmetrically.
  - A new car_req or same-direction hall request for cur_floor while the door is open restarts door_cnt and is not latched.
- Latency:
  - A request is visible in pend_* one cycle after it is sampled.
  - IDLE reacts on the next edge, so the motor starts two cycles after the request edge.
- Simultaneous events: if calls exist both above and below in IDLE, continue in the previous direction.
- Reset mid-move: returns immediately to floor 0 state; no position recovery.

Optional Feature:
- Macro ELEV_CAR_ESTOP_EN.
- When defined:
  - Adds input estop (1 bit).
  - While estop=1: motor_signal=00; travel_cnt and door_cnt freeze; state and cur_floor hold; calls still latch.
  - On release, the controller resumes from the frozen counts.
- When undefined: the port is absent and behaviour is as above.

Decomposition:
- Package elevator_pkg holds:
  - typedef enum for state {IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN};
  - motor codes MOTOR_STOP=2'b00, MOTOR_UP=2'b01, MOTOR_DN=2'b10;
  - dir_t typedef.
- One sub-module: elevator_call_scan (combinational). Inputs: the pending vectors and cur_floor. Outputs: above, below, here, and stop_up/stop_dn.

Test Plan:
- Reset, then hall_dn_req[7] pulse: motor_signal=01 for 28 cycles; cur_floor steps 0..7, one step every 4 cycles; door_open=1 for 8 cycles; pend_dn[7] clears; then IDLE with motor 00.
- At floor 7 with the door open, raise car_req[9] and car_req[2]: dir=UP, so the car serves 9 first, then moves down to 2.
- At floor 5 going up, latch hall_up_req[7] and hall_dn_req[6]: the car stops at 7 only, skips 6, and serves 6 on the way down.
- At floor 3 with the door open, pulse car_req[3] at door_cnt=6: the door stays open a further 8 cycles; pend_car[3] never sets.
- Assert rst low mid-move at floor 4: all outputs return to their reset values asynchronously, before the next clk edge.
- With ELEV_CAR_ESTOP_EN defined: assert estop for 10 cycles during MOVE_UP at travel_cnt=2; motor is 00 for those cycles, and the floor change arrives 10 cycles late.
